// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flag controller for a register-file FIFO.
// Drives the storage write enable and the write/read addresses. Tracks
// occupancy and publishes registered full/empty, threshold and sticky
// overflow/underflow status. Holds no data itself.
module fifo_ctrl #(
  parameter int ADDR_WIDTH      = 3,
  parameter int ALMOST_FULL_TH  = 6,  // 1 .. DEPTH
  parameter int ALMOST_EMPTY_TH = 1   // 0 .. DEPTH-1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  clr_err,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = CW'(1 << ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AF_TH_C = CW'(ALMOST_FULL_TH);
  localparam logic [ADDR_WIDTH:0] AE_TH_C = CW'(ALMOST_EMPTY_TH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  almost_full_q, almost_full_d;
  logic                  almost_empty_q, almost_empty_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  push_ok, pop_ok;

  // Accept/reject decisions and next-state for pointers, count, flags.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;

    // Requests are qualified by the registered flags of this cycle.
    push_ok = wr & ~full_q;
    pop_ok  = rd & ~empty_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;  // wraps modulo DEPTH
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Flags are derived from the next count so they line up with count.
    full_d         = (count_d == DEPTH_C);
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= AF_TH_C);
    almost_empty_d = (count_d <= AE_TH_C);

    // Sticky errors: a set condition in the same cycle beats clr_err.
    overflow_d  = (overflow_q  & ~clr_err) | (wr & full_q);
    underflow_d = (underflow_q & ~clr_err) | (rd & empty_q);
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // Storage is written only for accepted pushes, and never during reset.
  assign w_en         = push_ok & ~reset;
  assign w_addr       = wr_ptr_q;
  assign r_addr       = rd_ptr_q;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed bench for fifo_ctrl with a bench-side register file
// and a scoreboard queue of words expected at the head.
module tb_fifo_ctrl;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
  localparam int AF_TH = 6;
  localparam int AE_TH = 1;

  logic          clk = 1'b0;
  logic          reset, wr, rd, clr_err;
  logic          w_en;
  logic [AW-1:0] w_addr, r_addr;
  logic          full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  // Register-file storage beside the controller, as in the FIFO top.
  logic [7:0] mem [DEPTH];
  logic [7:0] w_data;
  logic [7:0] r_data;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state.
  int        m_count;
  int        m_wp, m_rp;
  bit        m_ovf, m_unf;
  logic [7:0] sb [$];

  fifo_ctrl #(
    .ADDR_WIDTH     (AW),
    .ALMOST_FULL_TH (AF_TH),
    .ALMOST_EMPTY_TH(AE_TH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr          (wr),
    .rd          (rd),
    .clr_err     (clr_err),
    .w_en        (w_en),
    .w_addr      (w_addr),
    .r_addr      (r_addr),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (w_en) mem[w_addr] <= w_data;
  assign r_data = mem[r_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every registered output with the reference state.
  task automatic chk_state(input string tag);
    chk({tag, ".count"},  32'(count),        32'(m_count));
    chk({tag, ".empty"},  32'(empty),        32'(m_count == 0));
    chk({tag, ".full"},   32'(full),         32'(m_count == DEPTH));
    chk({tag, ".af"},     32'(almost_full),  32'(m_count >= AF_TH));
    chk({tag, ".ae"},     32'(almost_empty), 32'(m_count <= AE_TH));
    chk({tag, ".w_addr"}, 32'(w_addr),       32'(m_wp));
    chk({tag, ".r_addr"}, 32'(r_addr),       32'(m_rp));
    chk({tag, ".ovf"},    32'(overflow),     32'(m_ovf));
    chk({tag, ".unf"},    32'(underflow),    32'(m_unf));
  endtask

  // One clock of traffic: check w_en and head data before the edge,
  // advance the reference, then check registered outputs after the edge.
  task automatic cycle(input string tag, input bit w, input bit r, input bit c,
                       input logic [7:0] d);
    bit push_ok, pop_ok;
    wr = w; rd = r; clr_err = c; w_data = d;
    #1;
    push_ok = w && (m_count != DEPTH);
    pop_ok  = r && (m_count != 0);
    chk({tag, ".w_en"}, 32'(w_en), 32'(push_ok));
    if (pop_ok) chk({tag, ".r_data"}, 32'(r_data), 32'(sb.pop_front()));
    if (push_ok) sb.push_back(d);
    m_ovf = (m_ovf && !c) || (w && m_count == DEPTH);
    m_unf = (m_unf && !c) || (r && m_count == 0);
    if (push_ok) m_wp = (m_wp + 1) % DEPTH;
    if (pop_ok)  m_rp = (m_rp + 1) % DEPTH;
    if (push_ok && !pop_ok) m_count++;
    if (pop_ok && !push_ok) m_count--;
    @(posedge clk); #1;
    chk_state(tag);
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; wr = 1'b1; rd = 1'b0; clr_err = 1'b0;
    #1;
    chk({tag, ".w_en_in_reset"}, 32'(w_en), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0; wr = 1'b0;
    m_count = 0; m_wp = 0; m_rp = 0; m_ovf = 0; m_unf = 0;
    sb.delete();
    chk_state(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; w_data = '0;
    @(posedge clk); #1;

    // Reset then idle.
    do_reset("rst");
    chk("rst.count0", 32'(count), 32'(0));
    chk("rst.empty1", 32'(empty), 32'(1));
    chk("rst.ae1",    32'(almost_empty), 32'(1));
    chk("rst.w_en0",  32'(w_en), 32'(0));
    cycle("idle", 0, 0, 0, 8'h00);

    // Fill with 0x11..0x88.
    for (int i = 1; i <= 8; i++) begin
      cycle($sformatf("push%0d", i), 1, 0, 0, 8'(i * 8'h11));
      if (i == 1) chk("push1.ae_still1", 32'(almost_empty), 32'(1));
      if (i == 2) chk("push2.ae_drop",   32'(almost_empty), 32'(0));
      if (i == 5) chk("push5.af0",       32'(almost_full), 32'(0));
      if (i == 6) chk("push6.af_rise",   32'(almost_full), 32'(1));
    end
    chk("full.flag",  32'(full),   32'(1));
    chk("full.count", 32'(count),  32'(8));
    chk("full.wwrap", 32'(w_addr), 32'(0));

    // Push while full.
    cycle("push9", 1, 0, 0, 8'h99);
    chk("push9.ovf",   32'(overflow), 32'(1));
    chk("push9.count", 32'(count),    32'(8));

    // clr_err together with a rejected push: set wins.
    cycle("clr_wr", 1, 0, 1, 8'h9A);
    chk("clr_wr.ovf", 32'(overflow), 32'(1));
    cycle("clr", 0, 0, 1, 8'h00);
    chk("clr.ovf", 32'(overflow),  32'(0));
    chk("clr.unf", 32'(underflow), 32'(0));

    // Drain, head data checked against the scoreboard.
    for (int i = 1; i <= 8; i++) cycle($sformatf("pop%0d", i), 0, 1, 0, 8'h00);
    chk("drain.rwrap", 32'(r_addr), 32'(0));
    chk("drain.empty", 32'(empty),  32'(1));
    cycle("pop9", 0, 1, 0, 8'h00);
    chk("pop9.unf",   32'(underflow), 32'(1));
    chk("pop9.count", 32'(count),     32'(0));
    cycle("clr2", 0, 0, 1, 8'h00);

    // Simultaneous push/pop at count=4.
    for (int i = 0; i < 4; i++) cycle("fill4", 1, 0, 0, 8'hC1 + 8'(i));
    cycle("both4", 1, 1, 0, 8'hC5);
    chk("both4.count", 32'(count),  32'(4));
    chk("both4.wp",    32'(w_addr), 32'(5));
    chk("both4.rp",    32'(r_addr), 32'(1));

    // Simultaneous at full.
    for (int i = 0; i < 4; i++) cycle("fill8", 1, 0, 0, 8'hD1 + 8'(i));
    cycle("bothfull", 1, 1, 0, 8'hDF);
    chk("bothfull.count", 32'(count),    32'(7));
    chk("bothfull.ovf",   32'(overflow), 32'(1));

    // Simultaneous at empty.
    for (int i = 0; i < 7; i++) cycle("drain7", 0, 1, 0, 8'h00);
    cycle("clr3", 0, 0, 1, 8'h00);
    cycle("bothempty", 1, 1, 0, 8'hE7);
    chk("bothempty.count", 32'(count),     32'(1));
    chk("bothempty.unf",   32'(underflow), 32'(1));
    chk("bothempty.head",  32'(r_data),    32'(8'hE7));
    cycle("popE7", 0, 1, 0, 8'h00);

    // Reset mid-stream at count=5.
    for (int i = 0; i < 5; i++) cycle("fill5", 1, 0, 0, 8'hF0 + 8'(i));
    chk("mid.count5", 32'(count), 32'(5));
    do_reset("midrst");
    chk("midrst.count", 32'(count),  32'(0));
    chk("midrst.wp",    32'(w_addr), 32'(0));
    chk("midrst.rp",    32'(r_addr), 32'(0));
    chk("midrst.unf",   32'(underflow), 32'(0));
    cycle("pushA5", 1, 0, 0, 8'hA5);
    chk("pushA5.head", 32'(r_data), 32'(8'hA5));
    cycle("popA5", 0, 1, 0, 8'h00);
    chk("popA5.empty", 32'(empty), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
